div_unit: RTL and testbench

Multi-cycle RV64 M-extension divider sitting between the register-file read ports and the register-file write port. It takes rs1/rs2 operand values plus the destination register number, and iterates a radix-2 restoring division. It then presents a 64-bit result on a valid/ready writeback port, which drives the register file's wdata/waddr/wen. It covers DIV, DIVU, REM, REMU and the W variants.

---
 rtl/div_unit_if.sv | 33 +++
 rtl/div_unit.sv | 196 +++++++++++++++++++
 tb/tb_div_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request and writeback handshake bundle for the M-extension divider

interface div_unit_if #(
   parameter int XLEN       = 64,
   parameter int ADDR_WIDTH = 5
);
   // request side
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            op;
   logic                  word;
   logic [XLEN-1:0]       rs1_rdata;
   logic [XLEN-1:0]       rs2_rdata;
   logic [ADDR_WIDTH-1:0] rd;
   logic                  flush;

   // writeback side
   logic                  wb_valid;
   logic                  wb_ready;
   logic [XLEN-1:0]       wdata;
   logic [ADDR_WIDTH-1:0] waddr;
   logic                  wen;

   modport master (
      output in_valid, op, word, rs1_rdata, rs2_rdata, rd, flush, wb_ready,
      input  in_ready, wb_valid, wdata, waddr, wen
   );

   modport slave (
      input  in_valid, op, word, rs1_rdata, rs2_rdata, rd, flush, wb_ready,
      output in_ready, wb_valid, wdata, waddr, wen
   );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU and W forms

module div_unit #(
   parameter int XLEN       = 64,
   parameter int ADDR_WIDTH = 5
) (
   input  logic     clk,
   input  logic     rst,
   div_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // iteration registers: dvd_q shifts the dividend out MSB-first and the quotient in LSB-first
   logic [XLEN-1:0]       dvd_q;
   logic [XLEN-1:0]       rem_q;
   logic [XLEN-1:0]       dvs_q;
   logic [5:0]            cnt;
   logic                  word_q;
   logic                  is_rem_q;
   logic                  neg_quo_q;
   logic                  neg_rem_q;
   logic [XLEN-1:0]       wdata_q;
   logic [ADDR_WIDTH-1:0] waddr_q;

   // accept-time operand preparation
   logic                  accept;
   logic                  op_signed;
   logic                  op_rem;
   logic [XLEN-1:0]       a_eff;
   logic [XLEN-1:0]       b_eff;
   logic                  a_neg;
   logic                  b_neg;
   logic [XLEN-1:0]       a_abs;
   logic [XLEN-1:0]       b_abs;
   logic [XLEN-1:0]       a_load;
   logic                  div_zero;
   logic                  sgn_ovf;
   logic                  special;
   logic [XLEN-1:0]       spec_res;

   // per-iteration step and final fix-up
   logic [XLEN:0]         trial;
   logic [XLEN-1:0]       rem_nxt;
   logic [XLEN-1:0]       dvd_nxt;
   logic [XLEN-1:0]       quo_raw;
   logic [XLEN-1:0]       quo_fin;
   logic [XLEN-1:0]       rem_fin;
   logic [XLEN-1:0]       res_sel;
   logic [XLEN-1:0]       res_fin;
   logic                  last;

   // a request is taken only in IDLE and never on a flush cycle
   assign accept = bus.in_valid & (state == IDLE) & ~bus.flush;

   // effective operands, absolute values, and the two short-circuit cases
   always_comb begin
      op_signed = ~bus.op[0];
      op_rem    = bus.op[1];
      a_eff     = bus.rs1_rdata;
      b_eff     = bus.rs2_rdata;
      if (bus.word) begin
         if (op_signed) begin
            a_eff = {{32{bus.rs1_rdata[31]}}, bus.rs1_rdata[31:0]};
            b_eff = {{32{bus.rs2_rdata[31]}}, bus.rs2_rdata[31:0]};
         end else begin
            a_eff = {32'b0, bus.rs1_rdata[31:0]};
            b_eff = {32'b0, bus.rs2_rdata[31:0]};
         end
      end
      a_neg  = op_signed & a_eff[XLEN-1];
      b_neg  = op_signed & b_eff[XLEN-1];
      a_abs  = a_neg ? -a_eff : a_eff;
      b_abs  = b_neg ? -b_eff : b_eff;
      // W ops park the 32-bit dividend in the top half so the same MSB-first shift applies
      a_load = bus.word ? {a_abs[31:0], 32'b0} : a_abs;

      div_zero = (b_eff == '0);
      sgn_ovf  = op_signed & (b_eff == '1) &
                 (a_eff == (bus.word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
      special  = div_zero | sgn_ovf;

      if (div_zero) begin
         spec_res = op_rem ? a_eff : '1;
      end else begin
         spec_res = op_rem ? '0 : a_eff;
      end
      if (bus.word) begin
         spec_res = {{32{spec_res[31]}}, spec_res[31:0]};
      end
   end

   // one restoring step plus the sign/selection fix-up used on the final step
   always_comb begin
      trial = {rem_q, dvd_q[XLEN-1]} - {1'b0, dvs_q};
      if (!trial[XLEN]) begin
         rem_nxt = trial[XLEN-1:0];
      end else begin
         rem_nxt = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
      end
      dvd_nxt = {dvd_q[XLEN-2:0], ~trial[XLEN]};

      quo_raw = word_q ? {32'b0, dvd_nxt[31:0]} : dvd_nxt;
      quo_fin = neg_quo_q ? -quo_raw : quo_raw;
      rem_fin = neg_rem_q ? -rem_nxt : rem_nxt;
      res_sel = is_rem_q ? rem_fin : quo_fin;
      res_fin = word_q ? {{32{res_sel[31]}}, res_sel[31:0]} : res_sel;

      last = (cnt == (word_q ? 6'd31 : 6'd63));
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic; flush overrides every transition
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = special ? DONE : CALC;
            end
         end
         CALC: begin
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.wb_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (bus.flush) begin
         state_nxt = IDLE;
      end
   end

   // operand capture at accept, iteration in CALC, result registered on the last step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         cnt       <= '0;
         word_q    <= 1'b0;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         wdata_q   <= '0;
         waddr_q   <= '0;
      end else if (accept) begin
         dvd_q     <= a_load;
         rem_q     <= '0;
         dvs_q     <= b_abs;
         cnt       <= '0;
         word_q    <= bus.word;
         is_rem_q  <= op_rem;
         neg_quo_q <= a_neg ^ b_neg;
         neg_rem_q <= a_neg;
         waddr_q   <= bus.rd;
         if (special) begin
            wdata_q <= spec_res;
         end
      end else if (state == CALC) begin
         dvd_q <= dvd_nxt;
         rem_q <= rem_nxt;
         cnt   <= cnt + 6'd1;
         if (last) begin
            wdata_q <= res_fin;
         end
      end
   end

   assign bus.in_ready = (state == IDLE);
   assign bus.wb_valid = (state == DONE);
   assign bus.wdata    = wdata_q;
   assign bus.waddr    = waddr_q;
   assign bus.wen      = (state == DONE) & bus.wb_ready & (waddr_q != '0);

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit

module tb_div_unit;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   cyc;
   logic seen;

   always #5 clk = ~clk;

   div_unit_if #(.XLEN(64), .ADDR_WIDTH(5)) dif ();

   div_unit #(.XLEN(64), .ADDR_WIDTH(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // present one request at a negedge, accept on the next posedge, then scramble the inputs
   task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd);
      @(negedge clk);
      chk("accept_ready", 64'(dif.in_ready), 64'd1);
      dif.in_valid  = 1'b1;
      dif.op        = op;
      dif.word      = word;
      dif.rs1_rdata = a;
      dif.rs2_rdata = b;
      dif.rd        = rd;
      @(posedge clk);
      #1;
      dif.in_valid  = 1'b0;
      dif.op        = 2'($urandom);
      dif.word      = 1'($urandom);
      dif.rs1_rdata = {$urandom, $urandom};
      dif.rs2_rdata = {$urandom, $urandom};
      dif.rd        = 5'($urandom);
   endtask

   // count cycles from cycle 1 until wb_valid is seen at a negedge (bounded)
   task automatic wait_wb(output int n);
      n = 1;
      @(negedge clk);
      while (!dif.wb_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input int lat, input logic [63:0] exp);
      int n;
      issue(op, word, a, b, rd);
      wait_wb(n);
      chk({tag, "_lat"},   64'(n), 64'(lat));
      chk({tag, "_wdata"}, dif.wdata, exp);
      chk({tag, "_waddr"}, 64'(dif.waddr), 64'(rd));
      chk({tag, "_wen"},   64'(dif.wen), (rd != 5'd0) ? 64'd1 : 64'd0);
      @(posedge clk);
      #1;
      chk({tag, "_wb_drop"}, 64'(dif.wb_valid), 64'd0);
      chk({tag, "_ready"},   64'(dif.in_ready), 64'd1);
   endtask

   initial begin
      rst           = 1'b1;
      dif.in_valid  = 1'b0;
      dif.op        = 2'b00;
      dif.word      = 1'b0;
      dif.rs1_rdata = '0;
      dif.rs2_rdata = '0;
      dif.rd        = '0;
      dif.flush     = 1'b0;
      dif.wb_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(dif.in_ready), 64'd1);
      chk("rst_wb_valid", 64'(dif.wb_valid), 64'd0);
      chk("rst_wen",      64'(dif.wen),      64'd0);
      chk("rst_wdata",    dif.wdata,         64'd0);
      chk("rst_waddr",    64'(dif.waddr),    64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("divu",      2'b01, 1'b0, 64'd100, 64'd7, 5'd5, 65, 64'd14);
      run_op("remu",      2'b11, 1'b0, 64'd100, 64'd7, 5'd5, 65, 64'd2);
      run_op("rem_neg",   2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 65, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("div_neg",   2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 65, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("div_zero",  2'b00, 1'b0, 64'h1234, 64'd0, 5'd11, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("remu_zero", 2'b11, 1'b0, 64'h1234, 64'd0, 5'd12, 1, 64'h1234);
      run_op("div_ovf",   2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 1, 64'h8000_0000_0000_0000);
      run_op("rem_ovf",   2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 1, 64'd0);
      run_op("divw",      2'b00, 1'b1, 64'h0000_0001_8000_0000, 64'd1, 5'd15, 33, 64'hFFFF_FFFF_8000_0000);
      run_op("divuw",     2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd16, 33, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("remw",      2'b10, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd17, 33, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("divw_ovf",  2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd18, 1, 64'hFFFF_FFFF_8000_0000);
      run_op("rd0",       2'b01, 1'b0, 64'd9, 64'd3, 5'd0, 65, 64'd3);

      // writeback backpressure with garbage on the operand inputs
      dif.wb_ready = 1'b0;
      issue(2'b01, 1'b0, 64'd1000, 64'd10, 5'd7);
      wait_wb(cyc);
      chk("bp_lat", 64'(cyc), 64'd65);
      repeat (10) begin
         @(posedge clk);
         #1;
         dif.rs1_rdata = {$urandom, $urandom};
         dif.rs2_rdata = {$urandom, $urandom};
         @(negedge clk);
         chk("bp_wdata",    dif.wdata,         64'd100);
         chk("bp_waddr",    64'(dif.waddr),    64'd7);
         chk("bp_in_ready", 64'(dif.in_ready), 64'd0);
         chk("bp_wen",      64'(dif.wen),      64'd0);
         chk("bp_wb_valid", 64'(dif.wb_valid), 64'd1);
      end
      dif.wb_ready = 1'b1;
      #1;
      chk("bp_wen_pulse", 64'(dif.wen), 64'd1);
      chk("bp_wdata_hs",  dif.wdata,    64'd100);
      @(posedge clk);
      #1;
      chk("bp_wen_after", 64'(dif.wen),      64'd0);
      chk("bp_wb_after",  64'(dif.wb_valid), 64'd0);

      // flush in CALC cycle 20
      issue(2'b01, 1'b0, 64'd100, 64'd7, 5'd3);
      repeat (19) @(posedge clk);
      #1;
      chk("flush_busy", 64'(dif.in_ready), 64'd0);
      dif.flush = 1'b1;
      @(posedge clk);
      #1;
      dif.flush = 1'b0;
      chk("flush_idle",  64'(dif.in_ready), 64'd1);
      chk("flush_no_wb", 64'(dif.wb_valid), 64'd0);
      seen = 1'b0;
      repeat (70) begin
         @(negedge clk);
         if (dif.wb_valid) seen = 1'b1;
      end
      chk("flush_quiet", 64'(seen), 64'd0);
      run_op("after_flush", 2'b01, 1'b0, 64'd9, 64'd3, 5'd4, 65, 64'd3);

      // flush coincident with an accept drops the request
      @(negedge clk);
      dif.in_valid  = 1'b1;
      dif.op        = 2'b01;
      dif.word      = 1'b0;
      dif.rs1_rdata = 64'd9;
      dif.rs2_rdata = 64'd3;
      dif.rd        = 5'd8;
      dif.flush     = 1'b1;
      @(posedge clk);
      #1;
      dif.in_valid = 1'b0;
      dif.flush    = 1'b0;
      chk("flush_acc_idle", 64'(dif.in_ready), 64'd1);
      seen = 1'b0;
      repeat (70) begin
         @(negedge clk);
         if (dif.wb_valid) seen = 1'b1;
      end
      chk("flush_acc_quiet", 64'(seen), 64'd0);

      // asynchronous reset in CALC cycle 30
      issue(2'b01, 1'b0, 64'd100, 64'd7, 5'd6);
      repeat (29) @(posedge clk);
      #1;
      chk("rst_mid_busy",  64'(dif.in_ready), 64'd0);
      chk("rst_mid_waddr", 64'(dif.waddr),    64'd6);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_in_ready", 64'(dif.in_ready), 64'd1);
      chk("rst_mid_wb_valid", 64'(dif.wb_valid), 64'd0);
      chk("rst_mid_wen",      64'(dif.wen),      64'd0);
      chk("rst_mid_wdata",    dif.wdata,         64'd0);
      chk("rst_mid_waddr0",   64'(dif.waddr),    64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("after_rst", 2'b01, 1'b0, 64'd9, 64'd3, 5'd4, 65, 64'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
